// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pacman_pkg
//  Purpose  : Shared maze geometry, direction bit indices, maze_probe state
//             codes and a constant shift-add multiply helper.
//  Revision : 1.0  initial release
// ============================================================================
package pacman_pkg;

    // Maze geometry in screen pixels / tiles
    localparam int TILE     = 28;
    localparam int X_ORIGIN = 24;
    localparam int Y_ORIGIN = 130;
    localparam int COLS     = 21;
    localparam int ROWS     = 12;

    // Bit positions inside a {left,up,right,down} can-go vector
    localparam int DIR_LEFT  = 3;
    localparam int DIR_UP    = 2;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 0;

    // maze_probe state codes
    localparam logic [2:0] MP_IDLE  = 3'd0;
    localparam logic [2:0] MP_DIV_X = 3'd1;
    localparam logic [2:0] MP_DIV_Y = 3'd2;
    localparam logic [2:0] MP_RD    = 3'd3;
    localparam logic [2:0] MP_DRAIN = 3'd4;
    localparam logic [2:0] MP_DONE  = 3'd5;

    // a * k for a constant k, built only from shifts and adds
    function automatic logic [15:0] mul_const(input logic [15:0] a, input int unsigned k);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) acc = acc + (a << i);
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_probe_if.sv
`default_nettype none
// ============================================================================
//  Module   : maze_probe_if
//  Purpose  : Query/response bundle between a sprite mover (master) and the
//             maze_probe responder (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface maze_probe_if;
    logic       req;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       busy;
    logic       valid;
    logic [3:0] can_go;
    logic       at_intersection;
    logic       oob;

    modport master (
        output req, pos_x, pos_y,
        input  busy, valid, can_go, at_intersection, oob
    );

    modport slave (
        input  req, pos_x, pos_y,
        output busy, valid, can_go, at_intersection, oob
    );
endinterface
`default_nettype wire

// File: rtl/maze_rom.sv
`default_nettype none
// ============================================================================
//  Module   : maze_rom
//  Purpose  : 1-bit wall map, one bit per tile (1 = wall), synchronous read
//             with one cycle of latency. Bit index = row*COLS + col.
//  Revision : 1.0  initial release
// ============================================================================
module maze_rom #(
    parameter int               DEPTH = 252,
    parameter int               AW    = 8,
    parameter logic [DEPTH-1:0] IMAGE = '0
)(
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic          data
);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic data_d;
    logic data_q;

    // Addresses past the end of the map read as wall
    always_comb begin
        data_d = 1'b1;
        if ({1'b0, addr} < C_DEPTH) data_d = IMAGE[addr];
    end

    // Registered read port
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;
endmodule
`default_nettype wire

// File: rtl/maze_probe.sv
`default_nettype none
// ============================================================================
//  Module   : maze_probe
//  Purpose  : Answers "which directions are open" for a sprite centre given in
//             screen pixels. Divides by the tile size through repeated
//             subtraction, then reads the four neighbour tiles from the wall
//             ROM one per cycle and forms the can-go vector.
//  Revision : 1.0  initial release
// ============================================================================
module maze_probe
    import pacman_pkg::MP_IDLE, pacman_pkg::MP_DIV_X, pacman_pkg::MP_DIV_Y,
           pacman_pkg::MP_RD, pacman_pkg::MP_DRAIN, pacman_pkg::MP_DONE,
           pacman_pkg::DIR_LEFT, pacman_pkg::DIR_UP, pacman_pkg::DIR_RIGHT,
           pacman_pkg::DIR_DOWN, pacman_pkg::mul_const;
#(
    parameter int                   TILE     = pacman_pkg::TILE,
    parameter int                   X_ORIGIN = pacman_pkg::X_ORIGIN,
    parameter int                   Y_ORIGIN = pacman_pkg::Y_ORIGIN,
    parameter int                   COLS     = pacman_pkg::COLS,
    parameter int                   ROWS     = pacman_pkg::ROWS,
    parameter logic [COLS*ROWS-1:0] MAZE     = '0
)(
    input  logic        clk,
    input  logic        reset,
    maze_probe_if.slave bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int QXW   = $clog2(COLS + 1);
    localparam int QYW   = $clog2(ROWS + 1);

    localparam logic signed [10:0] C_TILE   = 11'(TILE);
    localparam logic signed [10:0] C_HALF   = 11'(TILE / 2);
    localparam logic signed [10:0] C_X0     = 11'(X_ORIGIN);
    localparam logic signed [10:0] C_Y0     = 11'(Y_ORIGIN);
    localparam logic [QXW-1:0]     C_LAST_X = QXW'(COLS - 1);
    localparam logic [QYW-1:0]     C_LAST_Y = QYW'(ROWS - 1);

    logic [2:0]         state_q, state_d;
    logic signed [10:0] rx_q, rx_d, ry_q, ry_d;
    logic [QXW-1:0]     qx_q, qx_d;
    logic [QYW-1:0]     qy_q, qy_d;
    logic [1:0]         rd_idx_q, rd_idx_d;
    logic               pend_vld_q, pend_vld_d;
    logic [1:0]         pend_bit_q, pend_bit_d;
    logic               pend_in_q, pend_in_d;
    logic [3:0]         walls_q, walls_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [3:0]         can_go_q, can_go_d;
    logic               at_int_q, at_int_d;
    logic               oob_q, oob_d;

    logic signed [10:0] rx_entry, ry_entry;
    logic [QXW-1:0]     nb_x;
    logic [QYW-1:0]     nb_y;
    logic               nb_in;
    logic [AW-1:0]      rom_addr;
    logic               rom_data;
    logic               xc, yc;
    logic [3:0]         res_go;
    logic               finish, fin_oob;

    maze_rom #(
        .DEPTH (CELLS),
        .AW    (AW),
        .IMAGE (MAZE)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Neighbour selection for the current read slot (L, U, R, D); off-map neighbours skip the ROM
    always_comb begin
        nb_x  = qx_q;
        nb_y  = qy_q;
        nb_in = 1'b1;
        case (rd_idx_q)
            2'd0: begin nb_x = qx_q - QXW'(1); nb_in = (qx_q != '0);       end
            2'd1: begin nb_y = qy_q - QYW'(1); nb_in = (qy_q != '0);       end
            2'd2: begin nb_x = qx_q + QXW'(1); nb_in = (qx_q != C_LAST_X); end
            default: begin nb_y = qy_q + QYW'(1); nb_in = (qy_q != C_LAST_Y); end
        endcase
        rom_addr = nb_in ? AW'(mul_const(16'(nb_y), COLS) + 16'(nb_x)) : '0;
    end

    // Wall capture one cycle after each read, and the direction result from the remainders
    always_comb begin
        walls_d = walls_q;
        if (pend_vld_q) walls_d[pend_bit_q] = pend_in_q ? rom_data : 1'b1;
        xc = (rx_q == C_HALF);
        yc = (ry_q == C_HALF);
        res_go = '0;
        res_go[DIR_LEFT]  = yc & ((rx_q > C_HALF) | ~walls_d[DIR_LEFT]);
        res_go[DIR_RIGHT] = yc & ((rx_q < C_HALF) | ~walls_d[DIR_RIGHT]);
        res_go[DIR_UP]    = xc & ((ry_q > C_HALF) | ~walls_d[DIR_UP]);
        res_go[DIR_DOWN]  = xc & ((ry_q < C_HALF) | ~walls_d[DIR_DOWN]);
    end

    // Query FSM: accept, divide x, divide y, four neighbour reads, drain, report
    always_comb begin
        state_d    = state_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        qx_d       = qx_q;
        qy_d       = qy_q;
        rd_idx_d   = rd_idx_q;
        pend_vld_d = 1'b0;
        pend_bit_d = pend_bit_q;
        pend_in_d  = pend_in_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        can_go_d   = can_go_q;
        at_int_d   = at_int_q;
        oob_d      = oob_q;
        finish     = 1'b0;
        fin_oob    = 1'b0;
        // Offsets from the maze origin; the sign bit flags a position left of / above it
        rx_entry   = $signed({1'b0, bus.pos_x}) - C_X0;
        ry_entry   = $signed({1'b0, bus.pos_y}) - C_Y0;

        case (state_q)
            MP_IDLE: begin
                if (bus.req) begin
                    rx_d   = rx_entry;
                    ry_d   = ry_entry;
                    qx_d   = '0;
                    qy_d   = '0;
                    busy_d = 1'b1;
                    if (rx_entry[10] | ry_entry[10]) begin
                        finish  = 1'b1;
                        fin_oob = 1'b1;
                        state_d = MP_DONE;
                    end else begin
                        state_d = MP_DIV_X;
                    end
                end
            end
            MP_DIV_X: begin
                if (rx_q >= C_TILE) begin
                    rx_d = rx_q - C_TILE;
                    qx_d = qx_q + QXW'(1);
                    if (qx_q == C_LAST_X) begin
                        finish  = 1'b1;
                        fin_oob = 1'b1;
                        state_d = MP_DONE;
                    end
                end else begin
                    state_d = MP_DIV_Y;
                end
            end
            MP_DIV_Y: begin
                if (ry_q >= C_TILE) begin
                    ry_d = ry_q - C_TILE;
                    qy_d = qy_q + QYW'(1);
                    if (qy_q == C_LAST_Y) begin
                        finish  = 1'b1;
                        fin_oob = 1'b1;
                        state_d = MP_DONE;
                    end
                end else begin
                    rd_idx_d = 2'd0;
                    state_d  = MP_RD;
                end
            end
            MP_RD: begin
                // Read slot 0..3 maps onto bit 3..0 of the wall vector
                pend_vld_d = 1'b1;
                pend_bit_d = ~rd_idx_q;
                pend_in_d  = nb_in;
                rd_idx_d   = rd_idx_q + 2'd1;
                if (rd_idx_q == 2'd3) state_d = MP_DRAIN;
            end
            MP_DRAIN: begin
                finish  = 1'b1;
                state_d = MP_DONE;
            end
            MP_DONE: begin
                state_d = MP_IDLE;
            end
            default: begin
                state_d = MP_IDLE;
            end
        endcase

        // Results land together with the valid pulse; busy drops on the same edge
        if (finish) begin
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            oob_d    = fin_oob;
            can_go_d = fin_oob ? 4'b0000 : res_go;
            at_int_d = ~fin_oob & xc & yc;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= MP_IDLE;
            rx_q       <= '0;
            ry_q       <= '0;
            qx_q       <= '0;
            qy_q       <= '0;
            rd_idx_q   <= '0;
            pend_vld_q <= 1'b0;
            pend_bit_q <= '0;
            pend_in_q  <= 1'b0;
            walls_q    <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            can_go_q   <= '0;
            at_int_q   <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            qx_q       <= qx_d;
            qy_q       <= qy_d;
            rd_idx_q   <= rd_idx_d;
            pend_vld_q <= pend_vld_d;
            pend_bit_q <= pend_bit_d;
            pend_in_q  <= pend_in_d;
            walls_q    <= walls_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            can_go_q   <= can_go_d;
            at_int_q   <= at_int_d;
            oob_q      <= oob_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.valid           = valid_q;
    assign bus.can_go          = can_go_q;
    assign bus.at_intersection = at_int_q;
    assign bus.oob             = oob_q;
endmodule
`default_nettype wire

// File: tb/tb_maze_probe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maze_probe
//  Purpose  : Directed self-checking bench for maze_probe on a small test maze.
//  Revision : 1.0  initial release
// ============================================================================
module tb_maze_probe;
    import pacman_pkg::*;

    localparam int NCELL = COLS * ROWS;

    // Test maze: everything wall except a few hand-placed open tiles
    function automatic logic [NCELL-1:0] make_maze();
        logic [NCELL-1:0] m;
        m = '1;
        m[0*COLS + 0]   = 1'b0;                 // corner tile, walled right and below
        m[5*COLS + 4]   = 1'b0;                 // row 5 corridor 4..6
        m[5*COLS + 5]   = 1'b0;
        m[5*COLS + 6]   = 1'b0;
        m[8*COLS + 10]  = 1'b0;                 // four-way junction at (10,8)
        m[8*COLS + 9]   = 1'b0;
        m[8*COLS + 11]  = 1'b0;
        m[7*COLS + 10]  = 1'b0;
        m[9*COLS + 10]  = 1'b0;
        m[11*COLS + 20] = 1'b0;                 // bottom-right corner, open left and up
        m[11*COLS + 19] = 1'b0;
        m[10*COLS + 20] = 1'b0;
        return m;
    endfunction

    localparam logic [NCELL-1:0] TB_MAZE = make_maze();

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    maze_probe_if bus();

    maze_probe #(.MAZE(TB_MAZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One query; lat = edges after the accepting edge until valid is seen
    task automatic run_query(input int idx, input int px, input int py,
                             input logic [3:0] go, input logic at, input logic oob, input int lat);
        int cyc;
        int busy_cyc;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.pos_x = 10'(px);
        bus.pos_y = 10'(py);
        @(posedge clk); #1;
        bus.req = 1'b0;
        cyc = 0;
        busy_cyc = 0;
        while (!bus.valid && cyc < 100) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
        chk_eq($sformatf("q%0d_valid", idx),   32'(bus.valid), 1);
        chk_eq($sformatf("q%0d_latency", idx), cyc, lat);
        chk_eq($sformatf("q%0d_busy_cycles", idx), busy_cyc, lat);
        chk_eq($sformatf("q%0d_busy_at_valid", idx), 32'(bus.busy), 0);
        chk_eq($sformatf("q%0d_can_go", idx),  32'(bus.can_go), 32'(go));
        chk_eq($sformatf("q%0d_at_int", idx),  32'(bus.at_intersection), 32'(at));
        chk_eq($sformatf("q%0d_oob", idx),     32'(bus.oob), 32'(oob));
        @(posedge clk); #1;
        chk_eq($sformatf("q%0d_valid_pulse", idx), 32'(bus.valid), 0);
        chk_eq($sformatf("q%0d_can_go_hold", idx), 32'(bus.can_go), 32'(go));
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [3:0] go;
        logic       at;
        logic       oob;
        int         lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        int nv;
        int vpos [8];

        // x, y, {L,U,R,D}, at_intersection, oob, latency
        vecs[0] = '{38,  144, 4'b0000, 1'b1, 1'b0, 7};   // tile (0,0), everything closed
        vecs[1] = '{178, 284, 4'b1010, 1'b1, 1'b0, 17};  // corridor centre (5,5)
        vecs[2] = '{181, 284, 4'b1010, 1'b0, 1'b0, 17};  // 3 px right of centre
        vecs[3] = '{178, 281, 4'b0001, 1'b0, 1'b0, 17};  // 3 px above centre: down only
        vecs[4] = '{598, 452, 4'b1100, 1'b1, 1'b0, 38};  // bottom-right corner (20,11)
        vecs[5] = '{10,  200, 4'b0000, 1'b0, 1'b1, 0};   // left of maze
        vecs[6] = '{38,  100, 4'b0000, 1'b0, 1'b1, 0};   // above maze
        vecs[7] = '{612, 144, 4'b0000, 1'b0, 1'b1, 21};  // column 21: x divider aborts
        vecs[8] = '{38,  466, 4'b0000, 1'b0, 1'b1, 13};  // row 12: y divider aborts
        vecs[9] = '{318, 368, 4'b1111, 1'b1, 1'b0, 25};  // junction (10,8)

        reset     = 1'b0;
        bus.req   = 1'b0;
        bus.pos_x = '0;
        bus.pos_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy",   32'(bus.busy), 0);
        chk_eq("rst_valid",  32'(bus.valid), 0);
        chk_eq("rst_can_go", 32'(bus.can_go), 0);
        chk_eq("rst_at_int", 32'(bus.at_intersection), 0);
        chk_eq("rst_oob",    32'(bus.oob), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_query(i, vecs[i].x, vecs[i].y, vecs[i].go, vecs[i].at, vecs[i].oob, vecs[i].lat);
        end

        // Reset while dividing y: everything clears at once and no late valid appears
        @(negedge clk);
        bus.req   = 1'b1;
        bus.pos_x = 10'd178;
        bus.pos_y = 10'd284;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk_eq("mid_busy_before_reset", 32'(bus.busy), 1);
        #1;
        reset = 1'b0;
        #1;
        chk_eq("mid_rst_busy",   32'(bus.busy), 0);
        chk_eq("mid_rst_valid",  32'(bus.valid), 0);
        chk_eq("mid_rst_can_go", 32'(bus.can_go), 0);
        chk_eq("mid_rst_at_int", 32'(bus.at_intersection), 0);
        chk_eq("mid_rst_oob",    32'(bus.oob), 0);
        @(negedge clk);
        reset = 1'b1;
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.valid || bus.busy) vcount++;
        end
        chk_eq("no_stale_activity", vcount, 0);

        // req held high: one valid per query, a new query only starts from IDLE
        @(negedge clk);
        bus.req   = 1'b1;
        bus.pos_x = 10'd38;
        bus.pos_y = 10'd144;
        @(posedge clk); #1;
        nv = 0;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                if (nv < 8) vpos[nv] = k;
                nv++;
            end
        end
        @(negedge clk);
        bus.req = 1'b0;
        repeat (12) @(posedge clk);
        chk_eq("held_req_valid_count", nv, 3);
        if (nv >= 3) begin
            chk_eq("held_req_first_valid", vpos[0], 7);
            chk_eq("held_req_second_valid", vpos[1], 16);
            chk_eq("held_req_third_valid", vpos[2], 25);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
